// File: rtl/fft_stage_pipe_if.sv
// Vector handshake bundle for one radix-2 DIF FFT stage.
// The stage itself connects through the slave modport.
interface fft_stage_pipe_if #(
    parameter int W   = 16,
    parameter int NPT = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [NPT*W-1:0] din_re;
    logic [NPT*W-1:0] din_im;
    logic             scale;
    logic             out_valid;
    logic             out_ready;
    logic [NPT*W-1:0] dout_re;
    logic [NPT*W-1:0] dout_im;

    modport master (
        output in_valid, din_re, din_im, scale, out_ready,
        input  in_ready, out_valid, dout_re, dout_im
    );

    modport slave (
        input  in_valid, din_re, din_im, scale, out_ready,
        output in_ready, out_valid, dout_re, dout_im
    );
endinterface

// File: rtl/fft_stage_pipe.sv
// One radix-2 DIF butterfly stage: P1 add/sub with optional halving, P2 twiddle multiply.
// Two-entry stallable pipeline with sticky saturation flag.
module fft_stage_pipe #(
    parameter int W     = 16,
    parameter int LOG2N = 3,
    parameter int STAGE = 0
) (
    input  logic              clk,
    input  logic              rst,
    fft_stage_pipe_if.slave   bus,
    input  logic              clr_ovf,
    output logic              ovf
);
    localparam int NPT = 1 << LOG2N;
    localparam int NP  = NPT / 2;
    localparam int S   = NPT >> (STAGE + 1);
    localparam int XW  = W + 17;

    typedef logic signed [XW-1:0] ext_t;

    localparam ext_t MAXV = (ext_t'(1) <<< (W - 1)) - ext_t'(1);
    localparam ext_t MINV = -(ext_t'(1) <<< (W - 1));

    // Q1.14 cosine of 2*pi*k/16 for k = 0..7.
    function automatic logic signed [15:0] cos_q14(input int k);
        case (k)
            0:       return 16'sd16384;
            1:       return 16'sd15137;
            2:       return 16'sd11585;
            3:       return 16'sd6270;
            4:       return 16'sd0;
            5:       return -16'sd6270;
            6:       return -16'sd11585;
            7:       return -16'sd15137;
            default: return 16'sd0;
        endcase
    endfunction

    function automatic logic signed [15:0] sin_q14(input int k);
        return cos_q14((k >= 4) ? (k - 4) : (4 - k));
    endfunction

    // Returns {clipped, value[W-1:0]}.
    function automatic logic [W:0] sat(input ext_t x);
        ext_t y;
        logic clip;
        clip = 1'b1;
        if (x > MAXV)      y = MAXV;
        else if (x < MINV) y = MINV;
        else begin
            y    = x;
            clip = 1'b0;
        end
        return {clip, y[W-1:0]};
    endfunction

    logic             p1_valid;
    logic [NPT*W-1:0] p1_re, p1_im;
    logic [NPT*W-1:0] s1_re, s1_im, s2_re, s2_im;
    logic [NP-1:0]    s1_clip, s2_clip;
    logic             out_free, p1_free, accept, p2_load;

    for (genvar gi = 0; gi < NP; gi++) begin : g_pair
        localparam int JT = (gi / S) * 2 * S + (gi % S);
        localparam int JB = JT + S;
        localparam int K  = (gi % S) * (1 << STAGE) * (16 / NPT);
        localparam logic signed [15:0] C  = cos_q14(K);
        localparam logic signed [15:0] SN = sin_q14(K);

        ext_t sr, si, dr, di, pr, pm;
        logic signed [W-1:0] xr, xi;
        logic [W:0] q_sr, q_si, q_dr, q_di, q_pr, q_pm;

        always_comb begin
            sr = ext_t'($signed(bus.din_re[JT*W +: W])) + ext_t'($signed(bus.din_re[JB*W +: W]));
            si = ext_t'($signed(bus.din_im[JT*W +: W])) + ext_t'($signed(bus.din_im[JB*W +: W]));
            dr = ext_t'($signed(bus.din_re[JT*W +: W])) - ext_t'($signed(bus.din_re[JB*W +: W]));
            di = ext_t'($signed(bus.din_im[JT*W +: W])) - ext_t'($signed(bus.din_im[JB*W +: W]));
            if (bus.scale) begin
                sr = (sr + ext_t'(1)) >>> 1;
                si = (si + ext_t'(1)) >>> 1;
                dr = (dr + ext_t'(1)) >>> 1;
                di = (di + ext_t'(1)) >>> 1;
            end
            q_sr = sat(sr);
            q_si = sat(si);
            q_dr = sat(dr);
            q_di = sat(di);
        end

        // Twiddle k = 0 is unity, so it skips the rounding path entirely.
        always_comb begin
            xr = p1_re[JB*W +: W];
            xi = p1_im[JB*W +: W];
            if (K == 0) begin
                pr = ext_t'(xr);
                pm = ext_t'(xi);
            end else begin
                pr = (ext_t'(xr) * ext_t'(C) + ext_t'(xi) * ext_t'(SN) + ext_t'(8192)) >>> 14;
                pm = (ext_t'(xi) * ext_t'(C) - ext_t'(xr) * ext_t'(SN) + ext_t'(8192)) >>> 14;
            end
            q_pr = sat(pr);
            q_pm = sat(pm);
        end

        assign s1_re[JT*W +: W] = q_sr[W-1:0];
        assign s1_im[JT*W +: W] = q_si[W-1:0];
        assign s1_re[JB*W +: W] = q_dr[W-1:0];
        assign s1_im[JB*W +: W] = q_di[W-1:0];
        assign s1_clip[gi]      = q_sr[W] | q_si[W] | q_dr[W] | q_di[W];

        assign s2_re[JT*W +: W] = p1_re[JT*W +: W];
        assign s2_im[JT*W +: W] = p1_im[JT*W +: W];
        assign s2_re[JB*W +: W] = q_pr[W-1:0];
        assign s2_im[JB*W +: W] = q_pm[W-1:0];
        assign s2_clip[gi]      = q_pr[W] | q_pm[W];
    end

    assign out_free     = !bus.out_valid || bus.out_ready;
    assign p1_free      = !p1_valid || out_free;
    assign bus.in_ready = rst && p1_free;
    assign accept       = bus.in_valid && bus.in_ready;
    assign p2_load      = p1_valid && out_free;

    always_ff @(posedge clk) begin
        if (!rst) begin
            p1_valid      <= 1'b0;
            p1_re         <= '0;
            p1_im         <= '0;
            bus.out_valid <= 1'b0;
            bus.dout_re   <= '0;
            bus.dout_im   <= '0;
            ovf           <= 1'b0;
        end else begin
            if (p1_free)
                p1_valid <= accept;
            if (accept) begin
                p1_re <= s1_re;
                p1_im <= s1_im;
            end
            if (out_free)
                bus.out_valid <= p1_valid;
            if (p2_load) begin
                bus.dout_re <= s2_re;
                bus.dout_im <= s2_im;
            end
            // A new clamp outranks a simultaneous clear.
            if ((accept && |s1_clip) || (p2_load && |s2_clip))
                ovf <= 1'b1;
            else if (clr_ovf)
                ovf <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fft_stage_pipe.sv
// Scoreboard bench for fft_stage_pipe (8-point, stage 0): directed cases, stall, reset and random traffic.
module tb_fft_stage_pipe;
    localparam int W     = 16;
    localparam int LOG2N = 3;
    localparam int STAGE = 0;
    localparam int NPT   = 1 << LOG2N;
    localparam int S     = NPT >> (STAGE + 1);

    typedef logic [NPT*W-1:0] vec_t;
    typedef struct {
        vec_t re;
        vec_t im;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clr_ovf = 1'b0;
    logic ovf;

    fft_stage_pipe_if #(.W(W), .NPT(NPT)) bus();

    fft_stage_pipe #(.W(W), .LOG2N(LOG2N), .STAGE(STAGE)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .clr_ovf (clr_ovf),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cycle = 0;
    int n_out = 0;
    int first_out_cycle = -1;
    int accept_cycle = 0;
    sb_t exp_q[$];

    always @(posedge clk) cycle++;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic longint clampw(input longint x);
        longint hi, lo;
        hi = (longint'(1) <<< (W - 1)) - 1;
        lo = -(longint'(1) <<< (W - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    function automatic int rnd(input real r);
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
    endfunction

    // Reference butterfly built from real-valued twiddles rounded to Q1.14.
    function automatic sb_t model(input vec_t re, input vec_t im, input logic sc);
        sb_t e;
        longint ar, ai, br, bi, sr, si, dr, di, tr, ti;
        int k, c, s;
        real th;
        e.re = '0;
        e.im = '0;
        for (int j = 0; j < NPT; j++) begin
            if ((j % (2 * S)) < S) begin
                ar = longint'($signed(re[j*W +: W]));
                ai = longint'($signed(im[j*W +: W]));
                br = longint'($signed(re[(j+S)*W +: W]));
                bi = longint'($signed(im[(j+S)*W +: W]));
                sr = ar + br; si = ai + bi; dr = ar - br; di = ai - bi;
                if (sc) begin
                    sr = (sr + 1) >>> 1; si = (si + 1) >>> 1;
                    dr = (dr + 1) >>> 1; di = (di + 1) >>> 1;
                end
                sr = clampw(sr); si = clampw(si); dr = clampw(dr); di = clampw(di);
                k  = (j % S) * (1 << STAGE) * (16 / NPT);
                th = 2.0 * 3.14159265358979 * k / 16.0;
                c  = rnd(16384.0 * $cos(th));
                s  = rnd(16384.0 * $sin(th));
                if (k != 0) begin
                    tr = clampw((dr * c + di * s + 8192) >>> 14);
                    ti = clampw((di * c - dr * s + 8192) >>> 14);
                end else begin
                    tr = dr;
                    ti = di;
                end
                e.re[j*W +: W]     = sr[W-1:0];
                e.im[j*W +: W]     = si[W-1:0];
                e.re[(j+S)*W +: W] = tr[W-1:0];
                e.im[(j+S)*W +: W] = ti[W-1:0];
            end
        end
        return e;
    endfunction

    function automatic vec_t setel(input vec_t v, input int i, input int val);
        vec_t r;
        r = v;
        r[i*W +: W] = val[W-1:0];
        return r;
    endfunction

    always @(negedge clk) begin
        sb_t e;
        if (rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("dout_re", bus.dout_re, e.re);
                check("dout_im", bus.dout_im, e.im);
            end
            n_out++;
            if (first_out_cycle < 0) first_out_cycle = cycle;
            $display("out #%0d cycle %0d re=%h im=%h", n_out, cycle, bus.dout_re, bus.dout_im);
        end
    end

    task automatic send(input vec_t re, input vec_t im, input logic sc, input bit rand_bp);
        int t;
        bit done;
        t = 0;
        done = 0;
        bus.in_valid = 1'b1;
        bus.din_re   = re;
        bus.din_im   = im;
        bus.scale    = sc;
        while (!done) begin
            if (rand_bp) bus.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back(model(re, im, sc));
                accept_cycle = cycle;
                done = 1;
            end else if (++t > 100) begin
                check("send_timeout", 0, 1);
                done = 1;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        bus.out_ready = 1'b1;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        @(posedge clk); #1;
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        vec_t r, a, b, cv, snap_re, snap_im;
        int n0, t;
        bus.in_valid = 1'b0;
        bus.din_re = '0;
        bus.din_im = '0;
        bus.scale = 1'b0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("in_ready_in_reset", bus.in_ready, 0);
        check("out_valid_reset", bus.out_valid, 0);
        check("dout_re_reset", bus.dout_re, 0);
        check("ovf_reset", ovf, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("in_ready_idle", bus.in_ready, 1);

        r = setel('0, 0, 1000);
        send(r, '0, 1'b0, 0);
        drain();
        check("t1_re0", $signed(bus.dout_re[0*W +: W]), 1000);
        check("t1_re4", $signed(bus.dout_re[4*W +: W]), 1000);
        check("t1_ovf", ovf, 0);

        r = setel('0, 1, 1000);
        send(r, '0, 1'b0, 0);
        drain();
        check("t2_re1", $signed(bus.dout_re[1*W +: W]), 1000);
        check("t2_re5", $signed(bus.dout_re[5*W +: W]), 707);
        check("t2_im5", $signed(bus.dout_im[5*W +: W]), -707);

        r = setel('0, 0, 1001);
        send(r, '0, 1'b1, 0);
        drain();
        check("t3_re0", $signed(bus.dout_re[0*W +: W]), 501);
        check("t3_re4", $signed(bus.dout_re[4*W +: W]), 501);
        r = setel('0, 0, -3);
        send(r, '0, 1'b1, 0);
        drain();
        check("t3_neg_re0", $signed(bus.dout_re[0*W +: W]), -1);
        check("t3_neg_re4", $signed(bus.dout_re[4*W +: W]), -1);

        r = setel(setel('0, 0, 30000), 4, 30000);
        send(r, '0, 1'b0, 0);
        drain();
        check("t4_re0", $signed(bus.dout_re[0*W +: W]), 32767);
        check("t4_re4", $signed(bus.dout_re[4*W +: W]), 0);
        check("t4_ovf_set", ovf, 1);
        send(setel('0, 2, 77), '0, 1'b0, 0);
        drain();
        check("t4_ovf_sticky", ovf, 1);
        clr_ovf = 1'b1;
        @(posedge clk); #1;
        clr_ovf = 1'b0;
        check("t4_ovf_clear", ovf, 0);

        // Stall with both entries full, then release.
        a  = {$urandom, $urandom, $urandom, $urandom};
        b  = {$urandom, $urandom, $urandom, $urandom};
        cv = {$urandom, $urandom, $urandom, $urandom};
        bus.out_ready = 1'b0;
        send(a, b, 1'b1, 0);
        send(b, cv, 1'b1, 0);
        snap_re = bus.dout_re;
        snap_im = bus.dout_im;
        bus.in_valid = 1'b1;
        bus.din_re = cv;
        bus.din_im = a;
        bus.scale = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready", bus.in_ready, 0);
            check("stall_out_valid", bus.out_valid, 1);
            check("stall_hold_re", bus.dout_re, snap_re);
            check("stall_hold_im", bus.dout_im, snap_im);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        exp_q.push_back(model(cv, a, 1'b1));
        n0 = n_out;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("burst_count", n_out - n0, 3);
        check("burst_queue", exp_q.size(), 0);

        // Reset with two vectors in flight.
        bus.out_ready = 1'b0;
        send(setel('0, 0, 30000), setel('0, 4, -30000), 1'b0, 0);
        send(a, b, 1'b0, 0);
        check("pre_reset_ovf", ovf, 1);
        rst = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_dout_re", bus.dout_re, 0);
        check("rst_dout_im", bus.dout_im, 0);
        check("rst_ovf", ovf, 0);
        rst = 1'b1;
        bus.out_ready = 1'b1;
        first_out_cycle = -1;
        send(setel('0, 3, -1234), setel('0, 6, 555), 1'b0, 0);
        t = 0;
        while (first_out_cycle < 0 && t < 10) begin
            @(posedge clk); #1;
            t++;
        end
        check("latency", first_out_cycle - accept_cycle, 2);
        drain();

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            send({$urandom, $urandom, $urandom, $urandom},
                 {$urandom, $urandom, $urandom, $urandom},
                 1'($urandom_range(0, 1)), 1);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
